// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit, hazard unit and control decoder.
// Optional multiply-accumulate opcodes are enabled by defining MD_MADD_EN.
package md_pkg;

    localparam int unsigned MD_W      = 32;
    localparam int unsigned MD_OP_W   = 3;

    localparam logic [MD_OP_W-1:0] MD_OP_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_OP_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_OP_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_OP_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_OP_MTLO  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_OP_MADD  = 3'd6;
    localparam logic [MD_OP_W-1:0] MD_OP_MSUB  = 3'd7;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    typedef struct packed {
        logic [MD_W-1:0] hi;
        logic [MD_W-1:0] lo;
    } md_hilo_t;

    // Ops that occupy the unit for multiple cycles and commit to HI/LO.
    function automatic logic md_is_long_op(input logic [MD_OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            MD_OP_MADD, MD_OP_MSUB: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result generator for multiply, divide and (with MD_MADD_EN)
// multiply-accumulate; hi/lo inputs provide the pass-through and accumulate base.
module md_calc
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [MD_W-1:0]    src_a,
    input  logic [MD_W-1:0]    src_b,
    input  logic [MD_W-1:0]    hi,
    input  logic [MD_W-1:0]    lo,
    output logic [MD_W-1:0]    res_hi,
    output logic [MD_W-1:0]    res_lo,
    output logic               div_zero
);

    logic signed [2*MD_W-1:0] prod_s;
    logic        [2*MD_W-1:0] prod_u;
    logic                     div_ovf;
    logic signed [MD_W-1:0]   dvs_s;
    logic signed [MD_W-1:0]   quot_s;
    logic signed [MD_W-1:0]   rem_s;
    logic        [MD_W-1:0]   dvs_u;
    logic        [MD_W-1:0]   quot_u;
    logic        [MD_W-1:0]   rem_u;
`ifdef MD_MADD_EN
    logic        [2*MD_W-1:0] acc;
`endif

    // Zero divisor and INT_MIN/-1 both divide by one: the latter yields the
    // required quotient 0x80000000 with zero remainder, the former is discarded.
    always_comb begin
        div_zero = md_is_div(md_op) && (src_b == '0);
        div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

        prod_s = (2*MD_W)'($signed(src_a)) * (2*MD_W)'($signed(src_b));
        prod_u = (2*MD_W)'(src_a) * (2*MD_W)'(src_b);

        dvs_s  = (div_zero || div_ovf) ? 32'sd1 : $signed(src_b);
        quot_s = $signed(src_a) / dvs_s;
        rem_s  = $signed(src_a) % dvs_s;

        dvs_u  = div_zero ? 32'd1 : src_b;
        quot_u = src_a / dvs_u;
        rem_u  = src_a % dvs_u;

`ifdef MD_MADD_EN
        acc = '0;
`endif
        res_hi = hi;
        res_lo = lo;
        case (md_op)
            MD_OP_MULT:  {res_hi, res_lo} = $unsigned(prod_s);
            MD_OP_MULTU: {res_hi, res_lo} = prod_u;
            MD_OP_DIV: begin
                res_hi = $unsigned(rem_s);
                res_lo = $unsigned(quot_s);
            end
            MD_OP_DIVU: begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
`ifdef MD_MADD_EN
            MD_OP_MADD: begin
                acc = {hi, lo} + $unsigned(prod_s);
                {res_hi, res_lo} = acc;
            end
            MD_OP_MSUB: begin
                acc = {hi, lo} - $unsigned(prod_s);
                {res_hi, res_lo} = acc;
            end
`endif
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency multi-cycle ops plus
// single-cycle mthi/mtlo. MD_MADD_EN adds MADD/MSUB on md_op 6/7.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [MD_W-1:0]    src_a,
    input  logic [MD_W-1:0]    src_b,
    input  logic               flush,
    output logic               busy,
    output logic               stall_req,
    output logic [MD_W-1:0]    hi,
    output logic [MD_W-1:0]    lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [MD_W-1:0]    hi_q, hi_d;
    logic [MD_W-1:0]    lo_q, lo_d;
    md_hilo_t           pend_q, pend_d;
    logic               pend_zero_q, pend_zero_d;

    logic [MD_W-1:0]    calc_hi;
    logic [MD_W-1:0]    calc_lo;
    logic               calc_zero;

    md_calc u_calc (
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi       (hi_q),
        .lo       (lo_q),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_zero)
    );

    // Next-state: flush outranks both a new start and a pending commit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_d      = pend_q;
        pend_zero_d = pend_zero_q;

        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    if (md_is_long_op(md_op)) begin
                        pend_d.hi   = calc_hi;
                        pend_d.lo   = calc_lo;
                        pend_zero_d = calc_zero;
                        cnt_d       = md_is_div(md_op) ? CNT_W'(DIV_CYCLES - 1)
                                                       : CNT_W'(MULT_CYCLES - 1);
                        state_d     = MD_RUN;
                        busy_d      = 1'b1;
                    end else if (md_op == MD_OP_MTHI) begin
                        hi_d = src_a;
                    end else if (md_op == MD_OP_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            MD_RUN: begin
                if (flush) begin
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    if (!pend_zero_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            pend_q      <= '0;
            pend_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_q      <= pend_d;
            pend_zero_q <= pend_zero_d;
        end
    end

    assign busy      = busy_q;
    assign stall_req = start | busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner steps plus random ops
// checked against an arithmetic HI/LO model.
module tb_md_unit;
    import md_pkg::*;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_long(input logic [2:0] op);
`ifdef MD_MADD_EN
        return (op <= 3'd3) || (op >= 3'd6);
`else
        return op <= 3'd3;
`endif
    endfunction

    function automatic int lat(input logic [2:0] op);
        return (op == 3'd2 || op == 3'd3) ? DIV_N : MULT_N;
    endfunction

    // Architectural effect of one accepted op on the model HI/LO.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint sp;
        longint unsigned ua, ub;
        logic [63:0] acc;
        sa = $signed(a);
        sb = $signed(b);
        sp = longint'(sa) * longint'(sb);
        ua = a;
        ub = b;
        case (op)
            3'd0: {m_hi, m_lo} = sp;
            3'd1: {m_hi, m_lo} = ua * ub;
            3'd2: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
`ifdef MD_MADD_EN
            3'd6: begin acc = {m_hi, m_lo} + 64'(sp); {m_hi, m_lo} = acc; end
            3'd7: begin acc = {m_hi, m_lo} - 64'(sp); {m_hi, m_lo} = acc; end
`endif
            default: ;
        endcase
    endfunction

    // Multi-cycle op; poke>=0 drives a stray MTLO start in that busy cycle.
    task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
        logic [31:0] old_hi, old_lo;
        int n;
        old_hi = m_hi;
        old_lo = m_lo;
        n = lat(op);
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        #1;
        chk("stall_issue", 32'(stall_req), 32'd1);
        chk("busy_issue", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("stall_run", 32'(stall_req), 32'd1);
            chk("hi_hold", hi, old_hi);
            chk("lo_hold", lo, old_lo);
            if (k == poke) begin
                start = 1'b1; md_op = MD_OP_MTLO; src_a = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
        end
        model(op, a, b);
        chk("busy_done", 32'(busy), 32'd0);
        chk("hi_commit", hi, m_hi);
        chk("lo_commit", lo, m_lo);
    endtask

    // Single-cycle op (MTHI/MTLO/reserved), optionally with flush in the same cycle.
    task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input logic fl);
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = $urandom; flush = fl;
        #1;
        chk("stall_mt", 32'(stall_req), 32'd1);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        if (!fl && op == MD_OP_MTHI) m_hi = a;
        if (!fl && op == MD_OP_MTLO) m_lo = a;
        chk("busy_mt", 32'(busy), 32'd0);
        chk("hi_mt", hi, m_hi);
        chk("lo_mt", lo, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          poke;

        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle_stall", 32'(stall_req), 32'd0);

        run_mt(MD_OP_MTHI, 32'h1234_5678, 1'b0);
        run_mt(MD_OP_MTLO, 32'h9ABC_DEF0, 1'b0);
        chk("mt_hi_lit", hi, 32'h1234_5678);
        chk("mt_lo_lit", lo, 32'h9ABC_DEF0);

        run_long(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, -1);
        chk("mult_hi_lit", hi, 32'hFFFF_FFFF);
        chk("mult_lo_lit", lo, 32'hFFFF_FFFA);
        run_long(MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3, -1);
        chk("multu_hi_lit", hi, 32'h0000_0002);
        chk("multu_lo_lit", lo, 32'hFFFF_FFFA);
        run_long(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        chk("div_hi_lit", hi, 32'hFFFF_FFFF);
        chk("div_lo_lit", lo, 32'hFFFF_FFFD);
        run_long(MD_OP_DIVU, 32'd7, 32'd0, -1);
        chk("divz_hi_lit", hi, 32'hFFFF_FFFF);
        chk("divz_lo_lit", lo, 32'hFFFF_FFFD);
        run_long(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("divovf_hi_lit", hi, 32'd0);
        chk("divovf_lo_lit", lo, 32'h8000_0000);
        run_long(MD_OP_DIV, 32'd100, 32'd0, -1);

        // Stray start mid-run and in the commit cycle must be ignored.
        run_long(MD_OP_DIV, 32'd1000, 32'd7, 2);
        run_long(MD_OP_MULT, 32'h0001_0001, 32'h0002_0003, MULT_N - 1);

        // Flush during RUN: no commit, now or later.
        @(negedge clk);
        start = 1'b1; md_op = MD_OP_MULT; src_a = 32'h7FFF_FFFF; src_b = 32'h7FFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_hi", hi, m_hi);
        chk("flush_lo", lo, m_lo);
        repeat (MULT_N + 1) @(negedge clk);
        chk("flush_late_hi", hi, m_hi);
        chk("flush_late_lo", lo, m_lo);
        run_long(MD_OP_DIV, 32'hFFFF_FF00, 32'd16, -1);

        // Start dropped when flush arrives in the same cycle.
        @(negedge clk);
        start = 1'b1; md_op = MD_OP_DIVU; src_a = 32'd99; src_b = 32'd5; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flstart_busy", 32'(busy), 32'd0);
        repeat (DIV_N + 1) @(negedge clk);
        chk("flstart_hi", hi, m_hi);
        chk("flstart_lo", lo, m_lo);
        run_mt(MD_OP_MTHI, 32'hCAFE_F00D, 1'b1);

`ifdef MD_MADD_EN
        run_mt(MD_OP_MTHI, 32'd0, 1'b0);
        run_mt(MD_OP_MTLO, 32'hFFFF_FFFF, 1'b0);
        run_long(MD_OP_MADD, 32'd1, 32'd1, -1);
        chk("madd_hi_lit", hi, 32'd1);
        chk("madd_lo_lit", lo, 32'd0);
        run_long(MD_OP_MSUB, 32'd1, 32'd1, -1);
        chk("msub_hi_lit", hi, 32'd0);
        chk("msub_lo_lit", lo, 32'hFFFF_FFFF);
`else
        run_mt(3'd6, 32'h5555_5555, 1'b0);
        run_mt(3'd7, 32'hAAAA_AAAA, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (is_long(op)) begin
                poke = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat(op) - 1) : -1;
                run_long(op, a, b, poke);
            end else begin
                run_mt(op, a, 1'($urandom_range(0, 5) == 0));
            end
        end

        // Asynchronous reset in the middle of a run, with no later commit.
        run_mt(MD_OP_MTHI, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        start = 1'b1; md_op = MD_OP_MULT; src_a = 32'd12345; src_b = 32'd678;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (MULT_N + 2) @(negedge clk);
        chk("arst_late_hi", hi, m_hi);
        chk("arst_late_lo", lo, m_lo);
        chk("arst_late_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
